// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - signal bundle between fetch_sequencer, next-PC logic, ID stage and instruction memory
//
// Groups the redirect input, ID backpressure, the instruction-memory request and
// response channels, and the IF/ID output register into one interface.
//   master : the fetch sequencer (drives imem_req/imem_addr and if_*)
//   slave  : the surroundings (drive redirect_*, id_stall, imem_ready and imem_rsp_*)
// Optional macro FETCH_PERF_COUNTERS_EN adds perf_fetch_cnt, perf_redirect_cnt
// and perf_stall_cnt, driven by the master.

interface fetch_sequencer_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_redirect_cnt;
  logic [31:0] perf_stall_cnt;

  modport master (
    input  redirect_valid, redirect_pc, id_stall, imem_ready, imem_rsp_valid, imem_rsp_data,
    output imem_req, imem_addr, if_valid, if_pc, if_instr,
    output perf_fetch_cnt, perf_redirect_cnt, perf_stall_cnt
  );
  modport slave (
    output redirect_valid, redirect_pc, id_stall, imem_ready, imem_rsp_valid, imem_rsp_data,
    input  imem_req, imem_addr, if_valid, if_pc, if_instr,
    input  perf_fetch_cnt, perf_redirect_cnt, perf_stall_cnt
  );
`else
  modport master (
    input  redirect_valid, redirect_pc, id_stall, imem_ready, imem_rsp_valid, imem_rsp_data,
    output imem_req, imem_addr, if_valid, if_pc, if_instr
  );
  modport slave (
    output redirect_valid, redirect_pc, id_stall, imem_ready, imem_rsp_valid, imem_rsp_data,
    input  imem_req, imem_addr, if_valid, if_pc, if_instr
  );
`endif
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - IF-stage program counter and single-outstanding instruction fetch sequencer
//
// Owns the PC, issues one instruction-memory request at a time, accepts
// redirects from the next-PC logic (killing a stale in-flight fetch) and holds
// the fetched instruction in an output register under ID backpressure.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - fetch_sequencer_if.master: redirect_valid/redirect_pc, id_stall,
//          imem_req/imem_addr/imem_ready, imem_rsp_valid/imem_rsp_data,
//          if_valid/if_pc/if_instr
// Optional macro FETCH_PERF_COUNTERS_EN: adds fetch, redirect and stall counters.

module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic           clk,
  input  logic           rst,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        kill;
  logic        req_q;
  logic        if_valid_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_instr_q;

  logic        handshake;
  logic        consume;
  logic [31:0] redirect_target;

  // req_q is a separate flop so the request stays low during reset even
  // though the state already sits in REQ.
  assign handshake       = req_q && bus.imem_ready;
  assign consume         = if_valid_q && !bus.id_stall;
  assign redirect_target = bus.redirect_pc & ~32'h00000001;

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_instr  = if_instr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      req_pc     <= RESET_PC;
      kill       <= 1'b0;
      req_q      <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= RESET_PC;
      if_instr_q <= NOP_INSTR;
    end else begin
      // Default consumption; a load later in this block takes precedence.
      if (consume) begin
        if_valid_q <= 1'b0;
        if_instr_q <= NOP_INSTR;
      end

      if (bus.redirect_valid) begin
        pc         <= redirect_target;
        if_valid_q <= 1'b0;
        if_instr_q <= NOP_INSTR;
        case (state)
          S_REQ: begin
            if (handshake) begin
              // The request already left with the old address.
              req_pc <= pc;
              kill   <= 1'b1;
              state  <= S_WAIT;
              req_q  <= 1'b0;
            end else begin
              state <= S_REQ;
              req_q <= 1'b1;
            end
          end
          S_WAIT: begin
            if (bus.imem_rsp_valid) begin
              // The stale response is dropped right here, nothing left to kill.
              kill  <= 1'b0;
              state <= S_REQ;
              req_q <= 1'b1;
            end else begin
              kill <= 1'b1;
            end
          end
          default: begin
            state <= S_REQ;
            req_q <= 1'b1;
          end
        endcase
      end else begin
        case (state)
          S_REQ: begin
            if (handshake) begin
              req_pc <= pc;
              state  <= S_WAIT;
              req_q  <= 1'b0;
            end else begin
              req_q <= 1'b1;
            end
          end
          S_WAIT: begin
            if (bus.imem_rsp_valid) begin
              if (kill) begin
                kill  <= 1'b0;
                state <= S_REQ;
                req_q <= 1'b1;
              end else begin
                if_valid_q <= 1'b1;
                if_pc_q    <= req_pc;
                if_instr_q <= bus.imem_rsp_data;
                pc         <= req_pc + 32'd4;
                // The just-loaded instruction occupies the register next
                // cycle, so the next fetch waits in HOLD until ID takes it.
                state      <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (!bus.id_stall) begin
              state <= S_REQ;
              req_q <= 1'b1;
            end
          end
          default: begin
            state <= S_REQ;
            req_q <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_cnt;
  logic [31:0] redirect_cnt;
  logic [31:0] stall_cnt;

  assign bus.perf_fetch_cnt    = fetch_cnt;
  assign bus.perf_redirect_cnt = redirect_cnt;
  assign bus.perf_stall_cnt    = stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt    <= 32'd0;
      redirect_cnt <= 32'd0;
      stall_cnt    <= 32'd0;
    end else begin
      if ((state == S_WAIT) && bus.imem_rsp_valid && !kill && !bus.redirect_valid)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (bus.redirect_valid)
        redirect_cnt <= redirect_cnt + 32'd1;
      if (if_valid_q && bus.id_stall)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer

module tb_fetch_sequencer;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   rsp_delay;

  logic        m_pend;
  logic [31:0] m_addr;
  int          m_cnt;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(32'h00000000), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: data = 32'hAAAA0000 + address, valid rsp_delay
  // negedges after the request is seen (1 = the cycle after the accept edge).
  always @(negedge clk) begin
    if (rst) begin
      m_pend             = 1'b0;
      m_cnt              = 0;
      m_addr             = 32'd0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'd0;
    end else begin
      bus.imem_rsp_valid = 1'b0;
      if (m_pend) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = 32'hAAAA0000 + m_addr;
          m_pend             = 1'b0;
        end
      end
      if (bus.imem_req && bus.imem_ready) begin
        m_pend = 1'b1;
        m_addr = bus.imem_addr;
        m_cnt  = rsp_delay;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    rst                = 1'b1;
    bus.id_stall       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.imem_ready     = 1'b1;
    rsp_delay          = 1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst                = 1'b1;
    bus.id_stall       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.imem_ready     = 1'b1;
    rsp_delay          = 1;
    cyc(2);
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0h exp 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %08h exp 00000000", bus.imem_addr); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h exp 0", bus.if_valid); end
    checks++; if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %08h exp 00000000", bus.if_pc); end
    checks++; if (bus.if_instr !== NOP) begin errors++; $display("FAIL reset_instr: got %08h exp %08h", bus.if_instr, NOP); end
  endtask

  task automatic test_sequential;
    logic        exp_req, exp_valid;
    logic [31:0] exp_addr, exp_pc;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      cyc(1);
      exp_req   = (k % 3 == 1);
      exp_valid = (k % 3 == 0);
      exp_addr  = 32'((k - 1) / 3 * 4);
      exp_pc    = 32'((k / 3 - 1) * 4);
      checks++; if (bus.imem_req !== exp_req) begin errors++; $display("FAIL seq_req[%0d]: got %0h exp %0h", k, bus.imem_req, exp_req); end
      if (exp_req) begin
        checks++; if (bus.imem_addr !== exp_addr) begin errors++; $display("FAIL seq_addr[%0d]: got %08h exp %08h", k, bus.imem_addr, exp_addr); end
      end
      checks++; if (bus.if_valid !== exp_valid) begin errors++; $display("FAIL seq_valid[%0d]: got %0h exp %0h", k, bus.if_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (bus.if_pc !== exp_pc) begin errors++; $display("FAIL seq_pc[%0d]: got %08h exp %08h", k, bus.if_pc, exp_pc); end
        checks++; if (bus.if_instr !== (32'hAAAA0000 + exp_pc)) begin errors++; $display("FAIL seq_instr[%0d]: got %08h exp %08h", k, bus.if_instr, 32'hAAAA0000 + exp_pc); end
      end
    end
  endtask

  task automatic test_stall;
    do_reset();
    cyc(6);
    bus.id_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %0h exp 1", k, bus.if_valid); end
      checks++; if (bus.if_pc !== 32'h4) begin errors++; $display("FAIL stall_pc[%0d]: got %08h exp 00000004", k, bus.if_pc); end
      checks++; if (bus.if_instr !== 32'hAAAA0004) begin errors++; $display("FAIL stall_instr[%0d]: got %08h exp AAAA0004", k, bus.if_instr); end
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d]: got %0h exp 0", k, bus.imem_req); end
    end
    bus.id_stall = 1'b0;
    cyc(1);
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL stall_release_req: got %0h exp 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h8) begin errors++; $display("FAIL stall_release_addr: got %08h exp 00000008", bus.imem_addr); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid: got %0h exp 0", bus.if_valid); end
  endtask

  task automatic test_redirect_wait;
    do_reset();
    rsp_delay = 3;
    cyc(2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    cyc(1);
    bus.redirect_valid = 1'b0;
    rsp_delay          = 1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rw_req_wait: got %0h exp 0", bus.imem_req); end
    cyc(1);
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rw_valid_rsp: got %0h exp 0", bus.if_valid); end
    cyc(1);
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rw_valid_drop: got %0h exp 0", bus.if_valid); end
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL rw_req: got %0h exp 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL rw_addr: got %08h exp 00000100", bus.imem_addr); end
    cyc(2);
    checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL rw_new_valid: got %0h exp 1", bus.if_valid); end
    checks++; if (bus.if_pc !== 32'h100) begin errors++; $display("FAIL rw_new_pc: got %08h exp 00000100", bus.if_pc); end
    checks++; if (bus.if_instr !== 32'hAAAA0100) begin errors++; $display("FAIL rw_new_instr: got %08h exp AAAA0100", bus.if_instr); end
  endtask

  task automatic test_redirect_handshake;
    do_reset();
    cyc(7);
    checks++; if (bus.imem_addr !== 32'h8) begin errors++; $display("FAIL rh_pre_addr: got %08h exp 00000008", bus.imem_addr); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h201;
    cyc(1);
    bus.redirect_valid = 1'b0;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rh_req_wait: got %0h exp 0", bus.imem_req); end
    cyc(1);
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rh_valid_drop: got %0h exp 0", bus.if_valid); end
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL rh_req: got %0h exp 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h200) begin errors++; $display("FAIL rh_addr: got %08h exp 00000200", bus.imem_addr); end
    cyc(1);
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rh_valid_gap: got %0h exp 0", bus.if_valid); end
    cyc(1);
    checks++; if (bus.if_pc !== 32'h200) begin errors++; $display("FAIL rh_new_pc: got %08h exp 00000200", bus.if_pc); end
    checks++; if (bus.if_instr !== 32'hAAAA0200) begin errors++; $display("FAIL rh_new_instr: got %08h exp AAAA0200", bus.if_instr); end
  endtask

  task automatic test_redirect_flush;
    do_reset();
    cyc(3);
    bus.id_stall = 1'b1;
    cyc(1);
    checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL rf_pre_valid: got %0h exp 1", bus.if_valid); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    cyc(1);
    bus.redirect_valid = 1'b0;
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rf_valid: got %0h exp 0", bus.if_valid); end
    checks++; if (bus.if_instr !== NOP) begin errors++; $display("FAIL rf_instr: got %08h exp %08h", bus.if_instr, NOP); end
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL rf_req: got %0h exp 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h40) begin errors++; $display("FAIL rf_addr: got %08h exp 00000040", bus.imem_addr); end
    bus.id_stall = 1'b0;
    cyc(2);
    checks++; if (bus.if_pc !== 32'h40) begin errors++; $display("FAIL rf_new_pc: got %08h exp 00000040", bus.if_pc); end
    checks++; if (bus.if_instr !== 32'hAAAA0040) begin errors++; $display("FAIL rf_new_instr: got %08h exp AAAA0040", bus.if_instr); end
  endtask

  task automatic test_async_reset;
    do_reset();
    cyc(11);
    checks++; if (bus.if_pc !== 32'h8) begin errors++; $display("FAIL ar_pre_pc: got %08h exp 00000008", bus.if_pc); end
    checks++; if (bus.imem_addr !== 32'hC) begin errors++; $display("FAIL ar_pre_addr: got %08h exp 0000000C", bus.imem_addr); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL ar_req: got %0h exp 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL ar_addr: got %08h exp 00000000", bus.imem_addr); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %0h exp 0", bus.if_valid); end
    checks++; if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL ar_pc: got %08h exp 00000000", bus.if_pc); end
    checks++; if (bus.if_instr !== NOP) begin errors++; $display("FAIL ar_instr: got %08h exp %08h", bus.if_instr, NOP); end
    cyc(1);
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL ar_hold_req: got %0h exp 0", bus.imem_req); end
    #2 rst = 1'b0;
    cyc(1);
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL ar_restart_req: got %0h exp 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL ar_restart_addr: got %08h exp 00000000", bus.imem_addr); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_handshake();
    test_redirect_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Owns the program counter and sequences instruction-memory fetches for the IF stage, one outstanding request at a time. Accepts redirects computed by the next-PC logic (taken branch, JAL, JALR) and kills any in-flight fetch made stale by them. Holds the fetched instruction in an output register under ID-stage backpressure. Sits between the instruction memory port and the IF/ID pipeline register.

Parameters:
RESET_PC, 32'h00000000, PC loaded on reset
NOP_INSTR, 32'h00000013, value driven on if_instr when output is empty or flushed (ADDI x0,x0,0)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
redirect_valid  in  1  one-cycle pulse: next-PC logic selected a non-sequential target
redirect_pc  in  32  target; bit 0 forced to 0 internally; bits [1:0] == 2'b10 is illegal input
id_stall  in  1  ID cannot accept; output register must hold
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch word address
imem_ready  in  1  memory accepts request this cycle (handshake = imem_req && imem_ready)
imem_rsp_valid  in  1  response data valid; minimum 1 cycle after accept
imem_rsp_data  in  32  fetched instruction
if_valid  out  1  if_pc/if_instr hold a live instruction
if_pc  out  32  PC of the held instruction
if_instr  out  32  held instruction

Behaviour:
- Reset (async, rst=1): state=REQ; pc=RESET_PC; kill=0; if_valid=0; if_pc=RESET_PC; if_instr=NOP_INSTR. imem_req=0 while rst is asserted, then 1 from the first cycle after release. The memory is reset on the same reset; responses in flight across reset are not handled.
- Registered state: pc, req_pc, kill flag, output register, 2-bit state {REQ, WAIT, HOLD}.
- REQ: imem_req=1, imem_addr=pc. On handshake: req_pc<=pc, go to WAIT. The address may change while not accepted.
- WAIT: imem_req=0. On imem_rsp_valid with kill=1: drop the data, kill<=0, go to REQ. On imem_rsp_valid with kill=0: if_valid<=1, if_pc<=req_pc, if_instr<=imem_rsp_data, pc<=req_pc+4 (mod 2^32 wrap). Then go to REQ if the output register becomes free next cycle, else go to HOLD.
- Output consumption: the register is consumed on any cycle where if_valid && !id_stall. It then clears to if_valid=0, if_instr=NOP_INSTR unless it is reloaded in the same cycle.
- HOLD: imem_req=0. Stay in HOLD while id_stall=1. When id_stall=0, the instruction is consumed and the state goes to REQ.
- Best-case throughput: 1 instruction per 3 cycles (REQ accept, 1-cycle response, REQ).
- Redirect has the highest priority and is evaluated every cycle:
  - pc<={redirect_pc[31:1],1'b0}.
  - The output register is flushed (if_valid<=0, if_instr<=NOP_INSTR), even if id_stall=1.
  - In REQ without handshake: go to REQ. The new address appears next cycle.
  - In REQ with a same-cycle handshake: the request went out with the old address. Set kill<=1 and go to WAIT.
  - In WAIT without rsp_valid: set kill<=1 and stay in WAIT.
  - In WAIT with a same-cycle rsp_valid: drop the response, leave kill=0, go to REQ.
  - In HOLD: go to REQ.
- Back-to-back redirects: the last one wins, and kill stays set until a single response is dropped.
- No combinational path exists from imem_rsp_* to if_*. imem_req and imem_addr depend only on registered state.

Optional Feature:
Macro FETCH_PERF_COUNTERS_EN.
- Defined: adds outputs perf_fetch_cnt[31:0], perf_redirect_cnt[31:0] and perf_stall_cnt[31:0], all reset to 0 and wrapping at 2^32.
  - perf_fetch_cnt increments on each non-killed response delivered.
  - perf_redirect_cnt increments on each redirect_valid cycle.
  - perf_stall_cnt increments on each cycle where if_valid && id_stall.
- Undefined: these ports and counters do not exist. Core behaviour is identical in both builds.

Test Plan:
- Reset release, memory ready=1, 1-cycle latency returning 32'hAAAA0000+addr, id_stall=0 -> imem_addr sequence 0,4,8. if_pc 0,4,8 with the matching if_instr, one instruction every 3 cycles.
- Hold id_stall=1 for 5 cycles while if_valid=1 at if_pc=4 -> if_pc/if_instr stable and imem_req=0 throughout. The fetch of addr 8 is issued the cycle after id_stall drops.
- redirect_valid with redirect_pc=32'h100 in WAIT, response delayed 3 cycles -> the stale response is dropped and if_valid stays 0. The next imem_addr is 32'h100, then if_pc=32'h100.
- redirect_pc=32'h201 (JALR odd target) in the same cycle as a REQ handshake to addr 8 -> the addr-8 response is dropped and the next request is to 32'h200.
- redirect_valid while if_valid=1 and id_stall=1 -> if_valid=0 and if_instr=32'h00000013 next cycle. Fetch restarts at the target.
- rst asserted asynchronously mid-WAIT -> outputs reach their reset values before the next clock edge. After release the first request is to RESET_PC.
